// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the exception-source front end and CP0:
// controller state encoding, source count and CP0 cause codes.
package cpu_pkg;

    localparam int NUM_EXP_SRC = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } exp_state_e;

    // Cause codes CP0 reports for ExpSrc0..2.
    localparam logic [4:0] CAUSE_SRC0 = 5'd1;
    localparam logic [4:0] CAUSE_SRC1 = 5'd3;
    localparam logic [4:0] CAUSE_SRC2 = 5'd7;

    // Lowest-index set bit as a one-hot vector (zero if none set).
    function automatic logic [NUM_EXP_SRC-1:0] pick_winner(input logic [NUM_EXP_SRC-1:0] elig);
        pick_winner = elig & (~elig + 3'd1);
    endfunction

endpackage

// File: rtl/irq_debounce.sv
// Two-flop synchroniser, debounce counter and debounced level for one
// external request line, plus a one-cycle pulse on each debounced rise.
module irq_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic level_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q + 1'b1 == LIMIT) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/exp_src_ctrl.sv
// Exception-source front end for CP0: debounced edge capture, fixed-priority
// arbitration (source 0 highest) and a request/service handshake FSM.
module exp_src_ctrl
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] irq_in,
    input  logic [2:0] src_mask,
    input  logic       exp_block,
    input  logic       exp_taken,
    input  logic       is_eret,
    output logic [2:0] exp_src,
    output logic [2:0] pending,
    output logic [2:0] in_service,
    output logic       busy
);

    logic [NUM_EXP_SRC-1:0] level;
    logic [NUM_EXP_SRC-1:0] rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EXP_SRC; gi++) begin : g_deb
            irq_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_deb (
                .clk     (clk),
                .reset   (reset),
                .irq_in  (irq_in[gi]),
                .level_o (level[gi]),
                .rise_o  (rise[gi])
            );
        end
    endgenerate

    exp_state_e             state_q, state_d;
    logic [NUM_EXP_SRC-1:0] pending_q, pending_d;
    logic [NUM_EXP_SRC-1:0] exp_src_q, exp_src_d;
    logic [NUM_EXP_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_EXP_SRC-1:0] eligible;
    logic [NUM_EXP_SRC-1:0] clr;

    assign eligible = pending_q & ~src_mask & {NUM_EXP_SRC{~exp_block}};

    always_comb begin
        state_d      = state_q;
        exp_src_d    = exp_src_q;
        in_service_d = in_service_q;
        clr          = '0;
        unique case (state_q)
            ST_IDLE: begin
                exp_src_d = '0;
                if (|eligible) begin
                    state_d   = ST_REQ;
                    exp_src_d = pick_winner(eligible);
                end
            end
            ST_REQ: begin
                // Taken beats any same-cycle loss of eligibility.
                if (exp_taken) begin
                    state_d      = ST_SERVICE;
                    in_service_d = exp_src_q;
                    clr          = exp_src_q;
                    exp_src_d    = '0;
                end else if ((exp_src_q & eligible) == '0) begin
                    state_d   = ST_IDLE;
                    exp_src_d = '0;
                end
            end
            ST_SERVICE: begin
                exp_src_d = '0;
                if (is_eret) begin
                    state_d      = ST_IDLE;
                    in_service_d = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                exp_src_d    = '0;
                in_service_d = '0;
            end
        endcase
        // A fresh edge in the clearing cycle keeps the request pending.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            exp_src_q    <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            exp_src_q    <= exp_src_d;
            in_service_q <= in_service_d;
        end
    end

    assign exp_src    = exp_src_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign busy       = (state_q == ST_SERVICE);

endmodule
